osc_freq_meter: RTL and testbench
=================================

// Module: osc_freq_meter
// PURPOSE
//  Digital frequency meter for the on-die analog inverter/ring-oscillator test structures.
//  Selects one of NCH asynchronous oscillator outputs.
//  Counts its rising edges over a programmable gate window of clk cycles.
//  Returns a saturating count, so the analog cells can be characterised from the digital pins.
//  Sits between the analog macro outputs (via ua/ui_in) and the uo_out/uio readout logic.
// PARAMETERS
//  NCH     4   number of oscillator channels
//  CNT_W   16  width of edge count result
//  GATE_W  16  width of gate window length (clk cycles)
// PORTS
//  clk          in   1              system clock
//  rst          in   1              synchronous reset, active-high
//  ena          in   1              block enable; low aborts any measurement
//  osc_in       in   NCH            asynchronous oscillator outputs (digitised)
//  ch_sel       in   $clog2(NCH)    channel to measure, sampled on start
//  gate_cycles  in   GATE_W         gate window length, sampled on start
//  start        in   1              single-cycle request to begin a measurement
//  busy         out  1              measurement in progress (ARM or GATE)
//  done         out  1              one-cycle pulse: count valid
//  count        out  CNT_W          last completed edge count, held until next completion
//  overflow     out  1              last completed count saturated
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, count=0, overflow=0; synchronisers and accumulator cleared.
//  - Each osc_in bit passes through a 2-FF synchroniser.
//  - Rising edge = sync_now & ~sync_prev on the selected channel.
//  - Measurable input frequency is < clk/2; faster inputs alias and are not flagged.
//  - FSM: IDLE -> ARM -> GATE -> DONE -> IDLE.
//    - IDLE: start & ena -> latch ch_sel, gate_cycles; clear accumulator and sat flag.
//      - Latched gate_cycles==0 -> DONE directly, giving a 0 count.
//      - Otherwise -> ARM.
//    - ARM: exactly 1 cycle. Loads sync_prev from the newly selected channel; no edges counted.
//      Then -> GATE.
//    - GATE: lasts exactly gate_cycles clk cycles.
//      - Edges detected in these cycles increment the accumulator.
//      - At all-ones the accumulator holds and sets sat.
//    - DONE: 1 cycle.
//      - done=1; count<=accumulator; overflow<=sat.
//      - Then -> IDLE. A start in DONE is ignored.
//  - Timing: start sampled at cycle T gives ARM at T+1, GATE at T+2..T+1+G, done=1 at T+2+G.
//    count/overflow update on the same edge that raises done.
//  - busy=1 exactly in ARM and GATE; busy is registered from the state.
//  - start while busy is ignored, and ch_sel/gate_cycles changes mid-measurement have no effect.
//  - ena=0 in any state: next cycle state=IDLE, busy=0.
//    No done pulse; count/overflow retain the previous result.
//  - start with ena=0 is ignored.
//  - rst mid-measurement: all outputs return to reset values on the next edge.
//  - count and overflow change only in DONE.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> busy=0, done=0, count=0, overflow=0.
//  2. osc_in[1] toggling at clk/8 (period 8), ch_sel=1, gate_cycles=64, start -> done at T+66.
//     count=8 (+/-1), overflow=0, busy high for 65 cycles.
//  3. CNT_W=4 build, osc_in[0] at clk/4, gate_cycles=200, start -> count=15, overflow=1.
//  4. gate_cycles=0, start -> done at T+1, count=0, overflow=0, busy never high.
//  5. Channel selection: osc_in[2] at clk/4, osc_in[3] constant 0, ch_sel=3, gate 100 -> count=0.
//     Second start pulse mid-GATE ignored: one done only.
//  6. ena dropped at GATE cycle 10 -> IDLE next cycle, no done, count keeps the prior result.
//     Likewise rst mid-GATE -> all outputs zero.

Source files
------------

// File: rtl/osc_freq_meter.sv
// Gated edge counter for on-die ring-oscillator test structures.
// Picks one asynchronous oscillator input and counts its rising edges over a window of clk cycles.
module osc_freq_meter #(
  parameter int NCH    = 4,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [NCH-1:0]           osc_in,
  input  logic [$clog2(NCH)-1:0]   ch_sel,
  input  logic [GATE_W-1:0]        gate_cycles,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         count,
  output logic                     overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_GATE = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [NCH-1:0]           r_sync1;
  logic [NCH-1:0]           r_sync2;
  logic                     r_prev;
  logic [$clog2(NCH)-1:0]   r_ch;
  logic [GATE_W-1:0]        r_gate_left;
  logic [CNT_W-1:0]         r_acc;
  logic                     r_sat;
  logic                     r_busy;
  logic                     r_done;
  logic [CNT_W-1:0]         r_count;
  logic                     r_ovf;

  logic                     w_start_ok;
  logic                     w_edge;
  logic [CNT_W-1:0]         w_acc_next;
  logic                     w_sat_next;

  assign w_start_ok = (r_state == S_IDLE) && start && ena;
  assign w_edge     = (r_state == S_GATE) && r_sync2[r_ch] && !r_prev;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_next = (gate_cycles == '0) ? S_DONE : S_ARM;
      S_ARM:  w_next = S_GATE;
      S_GATE: if (r_gate_left == GATE_W'(1)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (!ena) w_next = S_IDLE;
  end

  // Saturating accumulator: at all-ones further edges only set the sticky flag.
  always_comb begin
    w_acc_next = r_acc;
    w_sat_next = r_sat;
    if (w_edge) begin
      if (&r_acc) w_sat_next = 1'b1;
      else        w_acc_next = r_acc + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_prev      <= 1'b0;
      r_ch        <= '0;
      r_gate_left <= '0;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_sync1 <= osc_in;
      r_sync2 <= r_sync1;
      // During ARM this primes the edge detector from the newly latched channel.
      r_prev  <= r_sync2[r_ch];
      r_state <= w_next;
      r_busy  <= (w_next == S_ARM) || (w_next == S_GATE);
      r_done  <= (w_next == S_DONE);
      if (w_start_ok) begin
        r_ch        <= ch_sel;
        r_gate_left <= gate_cycles;
        r_acc       <= '0;
        r_sat       <= 1'b0;
      end else if (r_state == S_GATE) begin
        r_gate_left <= r_gate_left - GATE_W'(1);
        r_acc       <= w_acc_next;
        r_sat       <= w_sat_next;
      end
      // Result includes the edge seen in the final gate cycle; a zero-length gate reports 0.
      if (w_next == S_DONE) begin
        r_count <= (r_state == S_GATE) ? w_acc_next : '0;
        r_ovf   <= (r_state == S_GATE) ? w_sat_next : 1'b0;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed bench for osc_freq_meter: a default build plus a 4-bit-count build share all inputs.
`timescale 1ns/1ps
module tb_osc_freq_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [3:0]  osc_in;
  logic [1:0]  ch_sel = 2'd0;
  logic [15:0] gate_cycles = 16'd0;
  logic        start = 1'b0;

  logic        busy, done, overflow;
  logic [15:0] count;
  logic        busy4, done4, overflow4;
  logic [3:0]  count4;

  logic osc0 = 1'b0, osc1 = 1'b0, osc2 = 1'b0;

  int total = 0;
  int bad   = 0;

  int done_at, busy_n, done_n;

  osc_freq_meter #(.NCH(4), .CNT_W(16), .GATE_W(16)) dut (
    .clk(clk), .rst(rst), .ena(ena), .osc_in(osc_in), .ch_sel(ch_sel),
    .gate_cycles(gate_cycles), .start(start), .busy(busy), .done(done),
    .count(count), .overflow(overflow)
  );

  osc_freq_meter #(.NCH(4), .CNT_W(4), .GATE_W(16)) dut4 (
    .clk(clk), .rst(rst), .ena(ena), .osc_in(osc_in), .ch_sel(ch_sel),
    .gate_cycles(gate_cycles), .start(start), .busy(busy4), .done(done4),
    .count(count4), .overflow(overflow4)
  );

  always #5 clk = ~clk;

  // clk period 10: osc0/osc2 have period 40 (clk/4), osc1 period 80 (clk/8), osc3 held low.
  initial begin #3; forever #20 osc0 = ~osc0; end
  initial begin #3; forever #20 osc2 = ~osc2; end
  initial begin #3; forever #40 osc1 = ~osc1; end
  assign osc_in = {1'b0, osc2, osc1, osc0};

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulses start with channel/gate, then runs 'budget' cycles sampling at negedge.
  // re_at: second start (with ch_sel=2) at that cycle; drop_at: ena low for 3 cycles; rst_at: 1-cycle reset.
  task automatic measure(input int ch, input int g, input int budget, input int re_at,
                         input int drop_at, input int rst_at,
                         output int d_at, output int b_n, output int d_n);
    d_at = -1; b_n = 0; d_n = 0;
    @(negedge clk);
    ch_sel = 2'(ch);
    gate_cycles = 16'(g);
    start = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (busy) b_n++;
      if (done) begin
        d_n++;
        if (d_at < 0) d_at = k;
      end
      start = (re_at != 0) && (k == re_at);
      if ((re_at != 0) && (k == re_at)) ch_sel = 2'd2;
      ena = !((drop_at != 0) && (k >= drop_at) && (k < drop_at + 3));
      rst = (rst_at != 0) && (k == rst_at);
    end
    start = 1'b0;
    ena = 1'b1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_count", count, 0);
    check_val("rst_ovf", overflow, 0);
    check_val("rst_count4", count4, 0);
    check_val("rst_ovf4", overflow4, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // clk/8 on channel 1, gate 64
    measure(1, 64, 80, 0, 0, 0, done_at, busy_n, done_n);
    check_val("t2_done_at", done_at, 66);
    check_val("t2_busy_cycles", busy_n, 65);
    check_val("t2_done_pulses", done_n, 1);
    check_val("t2_count_8pm1", int'((count >= 16'd7) && (count <= 16'd9)), 1);
    check_val("t2_ovf", overflow, 0);

    // start with ena low is ignored
    @(negedge clk);
    ena = 1'b0;
    gate_cycles = 16'd5;
    start = 1'b1;
    busy_n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done) busy_n++;
    end
    ena = 1'b1;
    check_val("ena0_start_ignored", busy_n, 0);

    // ena dropped in GATE cycle 10
    measure(1, 64, 80, 0, 11, 0, done_at, busy_n, done_n);
    check_val("ena_drop_busy_cycles", busy_n, 11);
    check_val("ena_drop_done_pulses", done_n, 0);
    check_val("ena_drop_count_kept", int'((count >= 16'd7) && (count <= 16'd9)), 1);
    check_val("ena_drop_ovf_kept", overflow, 0);

    // clk/4 on channel 0 for 200 cycles: 50 edges, saturating at 15 in the 4-bit build
    measure(0, 200, 210, 0, 0, 0, done_at, busy_n, done_n);
    check_val("t3_done_at", done_at, 202);
    check_val("t3_count16", count, 50);
    check_val("t3_ovf16", overflow, 0);
    check_val("t3_count4", count4, 15);
    check_val("t3_ovf4", overflow4, 1);

    // zero-length gate
    measure(0, 0, 6, 0, 0, 0, done_at, busy_n, done_n);
    check_val("t4_done_at", done_at, 1);
    check_val("t4_busy_cycles", busy_n, 0);
    check_val("t4_count", count, 0);
    check_val("t4_ovf", overflow, 0);
    check_val("t4_count4", count4, 0);

    // channel 3 (idle) while channel 2 toggles; second start mid-GATE ignored
    measure(3, 100, 120, 20, 0, 0, done_at, busy_n, done_n);
    check_val("t5_done_at", done_at, 102);
    check_val("t5_done_pulses", done_n, 1);
    check_val("t5_count", count, 0);

    // channel 2 check, then reset mid-GATE clears the result
    measure(2, 100, 110, 0, 0, 0, done_at, busy_n, done_n);
    check_val("t5b_count_ch2", count, 25);
    measure(2, 100, 110, 0, 0, 11, done_at, busy_n, done_n);
    check_val("rst_mid_busy_cycles", busy_n, 11);
    check_val("rst_mid_done_pulses", done_n, 0);
    check_val("rst_mid_count", count, 0);
    check_val("rst_mid_ovf", overflow, 0);
    check_val("rst_mid_count4", count4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
